// File: rtl/fnd_scan.sv
// Multiplexed 7-segment (FND) scan driver in the clock_50m domain; fnd_clk is sampled as data.
// Optional leading-zero blanking is enabled by defining FND_LZB_EN.
module fnd_scan #(
  parameter int DIGITS         = 8,
  parameter bit COM_ACTIVE_LOW = 1'b1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                clock_50m,
  input  logic                rst,
  input  logic                fnd_clk,
  input  logic                display_en,
  input  logic [4*DIGITS-1:0] digit_data,
  input  logic [DIGITS-1:0]   digit_blank,
  input  logic [DIGITS-1:0]   digit_dp,
  output logic [DIGITS-1:0]   fnd_com,
  output logic [7:0]          fnd_seg
);

  localparam int                IDX_W    = $clog2(DIGITS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] COM_OFF  = {DIGITS{COM_ACTIVE_LOW}};
  localparam logic [7:0]        SEG_OFF  = {8{SEG_ACTIVE_LOW}};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  logic r_s1, r_s2, r_s3;
  logic w_tick;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock_50m or negedge rst) begin
    if (!rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= fnd_clk;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_tick = r_s2 & ~r_s3;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic             w_load;

  always_ff @(posedge clock_50m or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_tick) begin
          w_state_nxt = ST_SCAN;
          w_idx_nxt   = '0;
          w_load      = 1'b1;
        end
      end
      ST_SCAN: begin
        if (w_tick) begin
          if (r_idx == LAST_IDX) begin
            w_idx_nxt = '0;
            w_load    = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  logic [DIGITS-1:0] w_in_blank;
  logic [DIGITS-1:0] w_in_dp;

`ifdef FND_LZB_EN
  logic [DIGITS-1:0] w_lzb;

  // A digit is auto-blanked when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    logic v_zero_run;
    v_zero_run = 1'b1;
    w_lzb      = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      v_zero_run = v_zero_run & (digit_data[4*i +: 4] == 4'h0);
      w_lzb[i]   = v_zero_run;
    end
  end

  assign w_in_blank = digit_blank | w_lzb;
  assign w_in_dp    = digit_dp & ~w_lzb;
`else
  assign w_in_blank = digit_blank;
  assign w_in_dp    = digit_dp;
`endif

  logic [4*DIGITS-1:0] r_snap_data;
  logic [DIGITS-1:0]   r_snap_blank;
  logic [DIGITS-1:0]   r_snap_dp;

  // NOTE: the snapshot is a handful of flops, not a RAM, so it takes the async reset like the rest.
  always_ff @(posedge clock_50m or negedge rst) begin
    if (!rst) begin
      r_snap_data  <= '0;
      r_snap_blank <= '0;
      r_snap_dp    <= '0;
    end else if (w_load) begin
      r_snap_data  <= digit_data;
      r_snap_blank <= w_in_blank;
      r_snap_dp    <= w_in_dp;
    end
  end

  // On a load edge the new frame's values bypass the snapshot so digit 0 shows them immediately.
  logic [4*DIGITS-1:0] w_src_data;
  logic [DIGITS-1:0]   w_src_blank;
  logic [DIGITS-1:0]   w_src_dp;
  logic [3:0]          w_nibble;
  logic                w_blank_sel;
  logic                w_dp_sel;
  logic [7:0]          w_seg_on;
  logic [DIGITS-1:0]   w_com_on;
  logic                w_drive;

  assign w_src_data  = w_load ? digit_data : r_snap_data;
  assign w_src_blank = w_load ? w_in_blank : r_snap_blank;
  assign w_src_dp    = w_load ? w_in_dp    : r_snap_dp;

  assign w_nibble    = w_src_data[{w_idx_nxt, 2'b00} +: 4];
  assign w_blank_sel = w_src_blank[w_idx_nxt];
  assign w_dp_sel    = w_src_dp[w_idx_nxt];

  assign w_seg_on = w_blank_sel ? 8'h00 : {w_dp_sel, hex_to_seg(w_nibble)};
  assign w_com_on = DIGITS'(1) << w_idx_nxt;
  assign w_drive  = display_en && (w_state_nxt == ST_SCAN);

  logic [DIGITS-1:0] r_com;
  logic [7:0]        r_seg;

  // Polarity is applied last by XOR with the inactive pattern.
  always_ff @(posedge clock_50m or negedge rst) begin
    if (!rst) begin
      r_com <= COM_OFF;
      r_seg <= SEG_OFF;
    end else if (w_drive) begin
      r_com <= w_com_on ^ COM_OFF;
      r_seg <= w_seg_on ^ SEG_OFF;
    end else begin
      r_com <= COM_OFF;
      r_seg <= SEG_OFF;
    end
  end

  assign fnd_com = r_com;
  assign fnd_seg = r_seg;

endmodule
